// File: rtl/bless_nic_if.sv
// Core-side and router-port-4 signal bundle for bless_nic.
// slave is the NIC view; master is the core/router view.
interface bless_nic_if;
    logic         inj_valid;
    logic         inj_ready;
    logic [5:0]   inj_dst;
    logic [127:0] inj_data;
    logic         port4_ready;
    logic [21:0]  port4_ci;
    logic [127:0] port4_di;
    logic [21:0]  port4_co;
    logic [127:0] port4_do;
    logic         ej_valid;
    logic         ej_ready;
    logic [5:0]   ej_src;
    logic [127:0] ej_data;

    modport slave (
        input  inj_valid, inj_dst, inj_data, port4_ready, port4_co, port4_do, ej_ready,
        output inj_ready, port4_ci, port4_di, ej_valid, ej_src, ej_data
    );

    modport master (
        output inj_valid, inj_dst, inj_data, port4_ready, port4_co, port4_do, ej_ready,
        input  inj_ready, port4_ci, port4_di, ej_valid, ej_src, ej_data
    );
endinterface

// File: rtl/bless_nic.sv
// Injection/ejection NIC for a bufferless deflection router port 4.
// Define BLESS_NIC_STATS_EN to add saturating inj/ej/stall counters.
module bless_nic #(
    parameter logic [5:0]  NODE_ID   = 6'd0,
    parameter int unsigned INJ_DEPTH = 4,
    parameter int unsigned EJ_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    bless_nic_if.slave  nic,
    input  logic        err_clr,
    output logic        err_ovf,
    output logic        err_misroute
`ifdef BLESS_NIC_STATS_EN
    ,
    output logic [15:0] stat_inj,
    output logic [15:0] stat_ej,
    output logic [15:0] stat_stall
`endif
);

    localparam int unsigned InjAw = $clog2(INJ_DEPTH);
    localparam int unsigned InjCw = InjAw + 1;
    localparam int unsigned EjAw  = $clog2(EJ_DEPTH);
    localparam int unsigned EjCw  = EjAw + 1;

    // ---------------- injection path ----------------
    logic [148:0]     inj_mem [INJ_DEPTH];  // {seq, src, dst, data}
    logic [InjAw-1:0] inj_wr_q, inj_rd_q;
    logic [InjAw:0]   inj_cnt_q;
    logic [8:0]       seq_q;
    logic             inj_full, inj_empty, inj_push, inj_pop;
    logic [148:0]     inj_head;

    // Depth is a power of two, so the count MSB alone marks full.
    assign inj_full      = inj_cnt_q[InjAw];
    assign inj_empty     = (inj_cnt_q == '0);
    assign inj_push      = nic.inj_valid && !inj_full;
    assign inj_pop       = !inj_empty && nic.port4_ready;
    assign inj_head      = inj_mem[inj_rd_q];
    assign nic.inj_ready = !inj_full;

    always_comb begin
        nic.port4_ci = '0;
        nic.port4_di = '0;
        if (inj_pop) begin
            nic.port4_ci = {1'b1, inj_head[148:128]};
            nic.port4_di = inj_head[127:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inj_wr_q  <= '0;
            inj_rd_q  <= '0;
            inj_cnt_q <= '0;
            seq_q     <= '0;
        end else begin
            if (inj_push) begin
                inj_wr_q <= inj_wr_q + InjAw'(1);
                seq_q    <= seq_q + 9'd1;
            end
            if (inj_pop) inj_rd_q <= inj_rd_q + InjAw'(1);
            if (inj_push && !inj_pop) inj_cnt_q <= inj_cnt_q + InjCw'(1);
            else if (!inj_push && inj_pop) inj_cnt_q <= inj_cnt_q - InjCw'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (inj_push) inj_mem[inj_wr_q] <= {seq_q, NODE_ID, nic.inj_dst, nic.inj_data};
    end

    // ---------------- ejection path ----------------
    logic [133:0]    ej_mem [EJ_DEPTH];  // {src, data}
    logic [EjAw-1:0] ej_wr_q, ej_rd_q;
    logic [EjAw:0]   ej_cnt_q;
    logic            ej_full, ej_empty, ej_push, ej_pop;
    logic            cap, dst_ok, ovf_set, mis_set;
    logic            err_ovf_q, err_mis_q;
    logic            unused_seq;

    assign ej_full    = ej_cnt_q[EjAw];
    assign ej_empty   = (ej_cnt_q == '0);
    assign ej_pop     = !ej_empty && nic.ej_ready;
    assign cap        = nic.port4_co[21];
    assign dst_ok     = (nic.port4_co[5:0] == NODE_ID);
    // A same-cycle pop frees the slot for the arriving flit.
    assign ej_push    = cap && dst_ok && (!ej_full || ej_pop);
    assign ovf_set    = cap && dst_ok && ej_full && !ej_pop;
    assign mis_set    = cap && !dst_ok;
    assign unused_seq = ^nic.port4_co[20:12];

    assign nic.ej_valid = !ej_empty;
    assign nic.ej_src   = ej_mem[ej_rd_q][133:128];
    assign nic.ej_data  = ej_mem[ej_rd_q][127:0];
    assign err_ovf      = err_ovf_q;
    assign err_misroute = err_mis_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ej_wr_q   <= '0;
            ej_rd_q   <= '0;
            ej_cnt_q  <= '0;
            err_ovf_q <= 1'b0;
            err_mis_q <= 1'b0;
        end else begin
            if (ej_push) ej_wr_q <= ej_wr_q + EjAw'(1);
            if (ej_pop) ej_rd_q <= ej_rd_q + EjAw'(1);
            if (ej_push && !ej_pop) ej_cnt_q <= ej_cnt_q + EjCw'(1);
            else if (!ej_push && ej_pop) ej_cnt_q <= ej_cnt_q - EjCw'(1);
            // New errors take priority over a clear in the same cycle.
            err_ovf_q <= ovf_set || (err_ovf_q && !err_clr);
            err_mis_q <= mis_set || (err_mis_q && !err_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (ej_push) ej_mem[ej_wr_q] <= {nic.port4_co[11:6], nic.port4_do};
    end

`ifdef BLESS_NIC_STATS_EN
    logic [15:0] stat_inj_q, stat_ej_q, stat_stall_q;

    assign stat_inj   = stat_inj_q;
    assign stat_ej    = stat_ej_q;
    assign stat_stall = stat_stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_inj_q   <= '0;
            stat_ej_q    <= '0;
            stat_stall_q <= '0;
        end else begin
            if (inj_pop && stat_inj_q != 16'hFFFF) stat_inj_q <= stat_inj_q + 16'd1;
            if (ej_push && stat_ej_q != 16'hFFFF) stat_ej_q <= stat_ej_q + 16'd1;
            if (!inj_empty && !nic.port4_ready && stat_stall_q != 16'hFFFF) begin
                stat_stall_q <= stat_stall_q + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/bless_nic.md
# bless_nic

Local network interface on the injection/ejection port (port 4) of a `brouter` bufferless deflection router. It accepts flits from the attached core and injects them into the router whenever the router grants a slot. It also captures every flit the router ejects, since a bufferless router cannot stall ejection, and queues those flits for the core. It stamps source ID and sequence number on outbound flits and flags misrouted or overflowed inbound traffic.

## Interface
- NODE_ID, 0, 6-bit ID of this node; written to src on injection, compared to dst on ejection
- INJ_DEPTH, 4, injection FIFO entries (power of two, ≥2)
- EJ_DEPTH, 4, ejection FIFO entries (power of two, ≥2)
- clk  in  1  clock, rising-edge
- rst  in  1  reset, asynchronous, active-low
- inj_valid  in  1  core offers a flit
- inj_ready  out  1  injection FIFO not full
- inj_dst  in  6  destination node ID
- inj_data  in  128  payload
- port4_ready  in  1  router can accept an injected flit this cycle
- port4_ci  out  22  control word to router port 4 (`control_w`)
- port4_di  out  128  data word to router port 4 (`data_w`)
- port4_co  in  22  ejected control word from router
- port4_do  in  128  ejected data word from router
- ej_valid  out  1  ejection FIFO head valid
- ej_ready  in  1  core consumes head
- ej_src  out  6  source ID of head flit
- ej_data  out  128  payload of head flit
- err_ovf  out  1  sticky: ejected flit dropped because FIFO was full
- err_misroute  out  1  sticky: ejected flit had dst ≠ NODE_ID
- err_clr  in  1  clears both sticky flags

## Operation
- Control word format: [21] valid, [20:12] seq (9 b), [11:6] src, [5:0] dst. Example: 22'h200001 is a valid flit with dst 1 and seq/src 0.
- Injection push: when inj_valid && inj_ready, enqueue {seq_ctr, NODE_ID, inj_dst, inj_data}. seq_ctr then increments and wraps from 511 to 0.
- Injection drive: port4_ci = {1, head fields} when FIFO non-empty && port4_ready. Otherwise port4_ci = 22'h0 and port4_di = 128'h0.
- Injection pop: on the edge where the flit is driven. Push and pop may occur in the same cycle.
- inj_ready = !full. A simultaneous pop does not open a slot in the same cycle.
- Ejection capture: every edge with port4_co[21] = 1.
  - dst ≠ NODE_ID: drop the flit and set err_misroute.
  - FIFO full and no pop this cycle: drop the flit and set err_ovf.
  - Otherwise: enqueue {src, data}.
- FIFO full with ej_valid && ej_ready in the same cycle: the arriving flit is accepted (pop, then push).
- Ejection pop: on ej_valid && ej_ready.
- err_clr: clears both sticky flags. If a new error occurs in the same cycle, set wins.

## Timing
- Reset (rst low, asynchronous) values:
  - FIFOs empty, seq_ctr = 0
  - inj_ready = 1, ej_valid = 0
  - port4_ci = 0, port4_di = 0
  - err flags = 0, stats counters = 0
- Injection latency: a flit pushed at edge N is driven combinationally in cycle N+1 if the FIFO was empty and port4_ready = 1. The router samples it at edge N+1.
- port4_ci/port4_di depend combinationally on port4_ready. No other path from an input to an output is combinational.
- Ejection latency: a flit captured at edge N gives ej_valid = 1 in cycle N+1 with ej_src/ej_data valid.
- Handshakes: data may not change while valid && !ready on either core-side interface.
- Reset mid-operation: all queued flits are discarded and no partial flit is driven.

## Configuration
- BLESS_NIC_STATS_EN defined adds three outputs and counters:
  - stat_inj[15:0] counts flits injected into the router.
  - stat_ej[15:0] counts flits enqueued for the core.
  - stat_stall[15:0] counts cycles with FIFO non-empty && !port4_ready.
  - All three saturate at 16'hFFFF, are cleared by reset, and are not affected by err_clr.
- Undefined: the ports and logic are absent, with no other behavioural change.

## Test plan
- Reset, NODE_ID=2, port4_ready=1, push dst=1, data=128'h0123456789abcdef0123456789abcdef → next cycle port4_ci=22'h200081, port4_di = that data; the cycle after, port4_ci=0.
- port4_ready=0, push 5 flits with INJ_DEPTH=4 → inj_ready=0 after the 4th push and the 5th is not taken. Raise port4_ready → flits are driven on 4 consecutive cycles with seq 0,1,2,3 in bits [20:12].
- Inject 513 flits with the router always ready → the 513th flit carries seq 0.
- NODE_ID=2, ej_ready=0, drive 5 ejected flits {valid, dst=2} → first 4 are queued, err_ovf=1 on the 5th. Then set ej_ready=1 → 4 pops in order.
- Ejected flit with dst=3 while NODE_ID=2 → err_misroute=1 and ej_valid stays 0. Pulse err_clr → flag 0. Pulse err_clr together with a new misroute → flag stays 1.
- Assert rst low mid-burst with both FIFOs half full → outputs return to reset values immediately; after release, inj_ready=1 and ej_valid=0.
